// File: rtl/misc_wb_pkg.sv
// rtl/misc_wb_pkg.sv - register map, field positions and blinker state encoding for misc_wb
package misc_wb_pkg;

  localparam logic [2:0] REG_BOOT = 3'd0;
  localparam logic [2:0] REG_TICK = 3'd1;
  localparam logic [2:0] REG_LED0 = 3'd2;

  localparam int LED_ENA_BIT  = 31;
  localparam int LED_OFF_LSB  = 16;
  localparam int BOOT_KEY_MSB = 31;
  localparam int BOOT_KEY_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/misc_blinker_ch.sv
// rtl/misc_blinker_ch.sv - one LED blinker channel: alternating on/off phases timed in ticks
module misc_blinker_ch
  import misc_wb_pkg::*;
#(
  parameter int TW = 11
) (
  input  logic          clk_24m,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic          ena,
  input  logic [TW-1:0] on,
  input  logic [TW-1:0] off,
  output logic          led
);

  blink_state_e  state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ena) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      // a restart takes priority over a tick landing on the same edge
      if (on != '0) begin
        state_d = ST_ON;
        cnt_d   = on;
      end else if (off != '0) begin
        state_d = ST_OFF;
        cnt_d   = off;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (tick) begin
      case (state_q)
        ST_ON: begin
          if (cnt_q <= TW'(1)) begin
            if (off != '0) begin
              state_d = ST_OFF;
              cnt_d   = off;
            end else begin
              cnt_d = on;
            end
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        ST_OFF: begin
          if (cnt_q <= TW'(1)) begin
            if (on != '0) begin
              state_d = ST_ON;
              cnt_d   = on;
            end else begin
              cnt_d = off;
            end
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led = (state_q == ST_ON);

endmodule

// File: rtl/misc_wb.sv
// rtl/misc_wb.sv - Wishbone system-control slave: keyed warmboot, tick counter, LED blinkers
module misc_wb
  import misc_wb_pkg::*;
#(
  parameter int         N_LED    = 1,
  parameter int         TW       = 11,
  parameter int         PRESCALE = 24000,
  parameter logic [7:0] BOOT_KEY = 8'hB0
) (
  input  logic             clk_24m,
  input  logic             rst,
  input  logic [2:0]       wb_addr,
  input  logic [31:0]      wb_wdata,
  output logic [31:0]      wb_rdata,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic             wb_ack,
  output logic             boot_now,
  output logic [1:0]       boot_sel,
  output logic [N_LED-1:0] led
);

  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);

  logic                       ack_q, ack_d;
  logic [31:0]                rdata_q, rdata_d, rd_mux;
  logic [PW-1:0]              presc_q, presc_d;
  logic                       tick;
  logic [31:0]                tick_cnt_q, tick_cnt_d;
  logic                       boot_now_q, boot_now_d;
  logic [1:0]                 boot_sel_q, boot_sel_d;
  logic [N_LED-1:0]           ena_q, ena_d;
  logic [N_LED-1:0][TW-1:0]   on_q, on_d, off_q, off_d;
  logic                       wr_en;
  logic [N_LED-1:0]           led_wr;
  logic                       unused_wdata;

  // the master holds addr/we/wdata through the ack cycle, so writes commit there
  assign wr_en        = ack_q & wb_we;
  assign tick         = (presc_q == '0);
  assign unused_wdata = ^wb_wdata;

  always_comb begin
    ack_d  = wb_cyc & ~ack_q;
    rd_mux = '0;
    case (wb_addr)
      REG_BOOT: rd_mux = {29'b0, boot_now_q, boot_sel_q};
      REG_TICK: rd_mux = tick_cnt_q;
      default:  rd_mux = '0;
    endcase
    for (int i = 0; i < N_LED; i++) begin
      if (wb_addr == REG_LED0 + 3'(i)) begin
        rd_mux[LED_ENA_BIT]         = ena_q[i];
        rd_mux[LED_OFF_LSB +: TW]   = off_q[i];
        rd_mux[TW-1:0]              = on_q[i];
      end
    end
    rdata_d = ack_d ? rd_mux : '0;

    presc_d = tick ? PRE_RELOAD : presc_q - PW'(1);

    tick_cnt_d = tick_cnt_q;
    if (wr_en && wb_addr == REG_TICK) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end

    boot_now_d = boot_now_q;
    boot_sel_d = boot_sel_q;
    if (wr_en && wb_addr == REG_BOOT && !boot_now_q &&
        wb_wdata[BOOT_KEY_MSB:BOOT_KEY_LSB] == BOOT_KEY) begin
      boot_sel_d = wb_wdata[1:0];
      boot_now_d = wb_wdata[2];
    end

    ena_d = ena_q;
    on_d  = on_q;
    off_d = off_q;
    for (int i = 0; i < N_LED; i++) begin
      if (led_wr[i]) begin
        ena_d[i] = wb_wdata[LED_ENA_BIT];
        on_d[i]  = wb_wdata[TW-1:0];
        off_d[i] = wb_wdata[LED_OFF_LSB +: TW];
      end
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      presc_q    <= PRE_RELOAD;
      tick_cnt_q <= '0;
      boot_now_q <= 1'b0;
      boot_sel_q <= '0;
      ena_q      <= '0;
      on_q       <= '0;
      off_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      boot_now_q <= boot_now_d;
      boot_sel_q <= boot_sel_d;
      ena_q      <= ena_d;
      on_q       <= on_d;
      off_q      <= off_d;
    end
  end

  // channels see the incoming fields on the write edge so the restart uses new periods
  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    assign led_wr[g] = wr_en && (wb_addr == REG_LED0 + 3'(g));

    misc_blinker_ch #(
      .TW(TW)
    ) u_ch (
      .clk_24m(clk_24m),
      .rst    (rst),
      .tick   (tick),
      .load   (led_wr[g]),
      .ena    (ena_d[g]),
      .on     (on_d[g]),
      .off    (off_d[g]),
      .led    (led[g])
    );
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign boot_now = boot_now_q;
  assign boot_sel = boot_sel_q;

endmodule
